// File: rtl/la_cmd_pkg.sv
// Shared definitions for the LA command bridge: LA input field positions,
// status word layout, opcode encoding and the parity helper.
package la_cmd_pkg;

   localparam int LA_PAYLOAD_LSB = 0;
   localparam int LA_OPCODE_LSB  = 24;
   localparam int LA_PARITY_BIT  = 27;
   localparam int LA_CLR_BIT     = 30;
   localparam int LA_STB_BIT     = 31;

   localparam int ST_COUNT_LSB = 0;
   localparam int ST_COUNT_W   = 4;
   localparam int ST_FULL_BIT  = 4;
   localparam int ST_EMPTY_BIT = 5;
   localparam int ST_OVF_BIT   = 6;
   localparam int ST_PERR_BIT  = 7;
   localparam int ST_ACC_LSB   = 8;
   localparam int ST_RSP_LSB   = 16;

   localparam int OPCODE_W = 3;
   localparam int ACC_W    = 8;
   localparam int RSP_W    = 16;

   typedef enum logic [OPCODE_W-1:0] {
      OP_NOP    = 3'd0,
      OP_LOAD   = 3'd1,
      OP_RUN    = 3'd2,
      OP_STOP   = 3'd3,
      OP_READ   = 3'd4,
      OP_SPARE5 = 3'd5,
      OP_SPARE6 = 3'd6,
      OP_SPARE7 = 3'd7
   } opcode_e;

   // Even parity over parity bit, opcode and payload: the XOR of all of them is 0.
   function automatic logic parity_ok(input logic [LA_PARITY_BIT:0] field);
      return ~(^field);
   endfunction

endpackage

// File: rtl/la_cmd_fifo.sv
// Small synchronous FIFO holding queued commands. A push into a full FIFO is
// still taken when a pop happens in the same cycle; push_ok reports whether
// the offered entry was actually written. Storage is not reset, only pointers.
module la_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 27
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     push_ok,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             rd_en;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_en   = pop && !empty;
   assign push_ok = push && (!full || rd_en);
   assign rdata   = mem[rd_ptr];

   // Entry storage: written on accepted pushes, deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/la_cmd_bridge.sv
// LA-to-core command bridge: detects strobe/clear toggles on the masked LA
// word, queues commands in la_cmd_fifo and reports status on la_data_out.
// Optional feature macro: LA_CMD_BRIDGE_PARITY_EN (drops pushes whose bit 27
// does not give even parity and raises a sticky parity error).
module la_cmd_bridge
   import la_cmd_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int PAYLOAD_W = 24
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic [31:0]          la_data_in,
   input  logic [31:0]          la_oenb,
   output logic [31:0]          la_data_out,
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   output logic [OPCODE_W-1:0]  cmd_opcode,
   output logic [PAYLOAD_W-1:0] cmd_payload,
   input  logic                 rsp_valid,
   input  logic [RSP_W-1:0]     rsp_data
);

   localparam int AW      = $clog2(DEPTH);
   localparam int ENTRY_W = OPCODE_W + PAYLOAD_W;

   logic [31:0]        m;
   logic               armed;
   logic               stb_q;
   logic               clr_q;
   logic               push_req;
   logic               clr_req;
   logic               par_ok;
   logic               fifo_push;
   logic               push_ok;
   logic               pop;
   logic               full;
   logic               empty;
   logic [AW:0]        count;
   logic [4:0]         cnt_ext;
   logic [ENTRY_W-1:0] wdata;
   logic [ENTRY_W-1:0] rdata;
   opcode_e            head_op;
   logic               ovf_q;
   logic               perr_q;
   logic [ACC_W-1:0]   acc_q;
   logic [RSP_W-1:0]   rsp_q;
   logic [31:0]        status;

   assign m         = la_data_in & ~la_oenb;
   assign push_req  = armed && (m[LA_STB_BIT] != stb_q);
   assign clr_req   = armed && (m[LA_CLR_BIT] != clr_q);
   assign fifo_push = push_req && par_ok;
   assign pop       = cmd_valid && cmd_ready;
   assign wdata     = {m[LA_OPCODE_LSB +: OPCODE_W], m[LA_PAYLOAD_LSB +: PAYLOAD_W]};

`ifdef LA_CMD_BRIDGE_PARITY_EN
   assign par_ok = parity_ok(m[LA_PARITY_BIT:0]);
`else
   assign par_ok = 1'b1;
`endif

   la_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .push    (fifo_push),
      .pop     (pop),
      .wdata   (wdata),
      .rdata   (rdata),
      .push_ok (push_ok),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   assign cmd_valid   = !empty;
   assign head_op     = opcode_e'(rdata[PAYLOAD_W +: OPCODE_W]);
   assign cmd_opcode  = head_op;
   assign cmd_payload = rdata[PAYLOAD_W-1:0];

   // Toggle tracking: the first clock after reset only snapshots the toggle
   // bits, so a strobe already high at reset release never fires a command.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         armed <= 1'b0;
         stb_q <= 1'b0;
         clr_q <= 1'b0;
      end else begin
         armed <= 1'b1;
         stb_q <= m[LA_STB_BIT];
         clr_q <= m[LA_CLR_BIT];
      end
   end

   // Overflow flag and accepted counter; a same-cycle write wins over clear.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ovf_q <= 1'b0;
         acc_q <= '0;
      end else begin
         ovf_q <= (ovf_q && !clr_req) || (fifo_push && !push_ok);
         if (clr_req) begin
            acc_q <= ACC_W'(push_ok);
         end else if (push_ok) begin
            acc_q <= acc_q + ACC_W'(1);
         end
      end
   end

`ifdef LA_CMD_BRIDGE_PARITY_EN
   // Sticky parity error raised by any strobe flip carrying bad parity.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= (perr_q && !clr_req) || (push_req && !par_ok);
      end
   end
`else
   assign perr_q = 1'b0;
`endif

   // Latest core response, held until the next response strobe.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         rsp_q <= '0;
      end else if (rsp_valid) begin
         rsp_q <= rsp_data;
      end
   end

   assign cnt_ext = 5'(count);

   // Status word assembled purely from registered state.
   always_comb begin
      status = '0;
      status[ST_COUNT_LSB +: ST_COUNT_W] = cnt_ext[3:0];
      status[ST_FULL_BIT]                = full;
      status[ST_EMPTY_BIT]               = empty;
      status[ST_OVF_BIT]                 = ovf_q;
      status[ST_PERR_BIT]                = perr_q;
      status[ST_ACC_LSB +: ACC_W]        = acc_q;
      status[ST_RSP_LSB +: RSP_W]        = rsp_q;
   end

   assign la_data_out = status;

   wire unused_bits = ^{m[29:LA_PARITY_BIT], cnt_ext[4]};

endmodule
